// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared constants for the register-file write-back arbiter
package rf_wb_arbiter_pkg;

  localparam int XLEN           = 32;
  localparam int NREG           = 32;
  localparam int REG_AW         = $clog2(NREG);
  localparam int STARVE_LIM_DEF = 4;
  localparam int STARVE_CW      = 4;

  localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rtl/rf_wb_arbiter_if.sv - producer handshakes and register-file write port bundle
interface rf_wb_arbiter_if #(
  parameter int XLEN = rf_wb_arbiter_pkg::XLEN,
  parameter int AW   = rf_wb_arbiter_pkg::REG_AW
) ();

  logic            alu_valid_i;
  logic [AW-1:0]   alu_wa_i;
  logic [XLEN-1:0] alu_wd_i;
  logic            alu_ready_o;

  logic            lsu_valid_i;
  logic [AW-1:0]   lsu_wa_i;
  logic [XLEN-1:0] lsu_wd_i;
  logic            lsu_ready_o;

  logic            rf_we_o;
  logic [AW-1:0]   rf_wa_o;
  logic [XLEN-1:0] rf_wd_o;

  modport master (
    output alu_valid_i, alu_wa_i, alu_wd_i,
    input  alu_ready_o,
    output lsu_valid_i, lsu_wa_i, lsu_wd_i,
    input  lsu_ready_o,
    input  rf_we_o, rf_wa_o, rf_wd_o
  );

  modport slave (
    input  alu_valid_i, alu_wa_i, alu_wd_i,
    output alu_ready_o,
    input  lsu_valid_i, lsu_wa_i, lsu_wd_i,
    output lsu_ready_o,
    output rf_we_o, rf_wa_o, rf_wd_o
  );

endinterface

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending-write bits with two hazard read ports
module rf_scoreboard #(
  parameter int NREG = rf_wb_arbiter_pkg::NREG
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_set_en,
  input  logic [$clog2(NREG)-1:0] i_set_addr,
  input  logic                    i_clr_en,
  input  logic [$clog2(NREG)-1:0] i_clr_addr,
  input  logic [$clog2(NREG)-1:0] i_ra1,
  input  logic [$clog2(NREG)-1:0] i_ra2,
  output logic                    o_hazard
);
  import rf_wb_arbiter_pkg::*;

  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;

  // Set is applied after clear so a newly issued producer wins a same-cycle commit.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_en) w_busy_nxt[i_clr_addr] = 1'b0;
    if (i_set_en) w_busy_nxt[i_set_addr] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  assign o_hazard = r_busy[i_ra1] | r_busy[i_ra2];

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - ALU/LSU write-back arbiter with starvation guard and RAW scoreboard
module rf_wb_arbiter #(
  parameter int XLEN       = rf_wb_arbiter_pkg::XLEN,
  parameter int NREG       = rf_wb_arbiter_pkg::NREG,
  parameter int STARVE_LIM = rf_wb_arbiter_pkg::STARVE_LIM_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  rf_wb_arbiter_if.slave          bus,
  input  logic                    issue_i,
  input  logic [$clog2(NREG)-1:0] issue_rd_i,
  input  logic [$clog2(NREG)-1:0] chk_ra1_i,
  input  logic [$clog2(NREG)-1:0] chk_ra2_i,
  output logic                    hazard_o
);
  import rf_wb_arbiter_pkg::*;

  localparam int AW = $clog2(NREG);

  logic [STARVE_CW-1:0] r_starve_cnt;
  logic                 r_we;
  logic [AW-1:0]        r_wa;
  logic [XLEN-1:0]      r_wd;

  logic            w_force_alu;
  logic            w_alu_xfer;
  logic            w_lsu_xfer;
  logic            w_wr;
  logic [AW-1:0]   w_sel_wa;
  logic [XLEN-1:0] w_sel_wd;

  // LSU has priority unless the ALU has been refused STARVE_LIM times in a row.
  assign w_force_alu     = (r_starve_cnt == STARVE_CW'(STARVE_LIM));
  assign bus.lsu_ready_o = !w_force_alu;
  assign bus.alu_ready_o = w_force_alu || !bus.lsu_valid_i;

  assign w_alu_xfer = bus.alu_valid_i && bus.alu_ready_o;
  assign w_lsu_xfer = bus.lsu_valid_i && bus.lsu_ready_o;
  assign w_sel_wa   = w_alu_xfer ? bus.alu_wa_i : bus.lsu_wa_i;
  assign w_sel_wd   = w_alu_xfer ? bus.alu_wd_i : bus.lsu_wd_i;
  assign w_wr       = (w_alu_xfer || w_lsu_xfer) && (w_sel_wa != REG_ZERO);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_we         <= 1'b0;
      r_wa         <= '0;
      r_wd         <= '0;
    end else begin
      r_we <= w_wr;
      if (w_wr) begin
        r_wa <= w_sel_wa;
        r_wd <= w_sel_wd;
      end
      if (!bus.alu_valid_i || w_alu_xfer)
        r_starve_cnt <= '0;
      else if (!w_force_alu)
        r_starve_cnt <= r_starve_cnt + STARVE_CW'(1);
    end
  end

  assign bus.rf_we_o = r_we;
  assign bus.rf_wa_o = r_wa;
  assign bus.rf_wd_o = r_wd;

  // The committing write clears its busy bit at the edge where rf_we_o is seen.
  rf_scoreboard #(.NREG(NREG)) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .i_set_en   (issue_i),
    .i_set_addr (issue_rd_i),
    .i_clr_en   (r_we),
    .i_clr_addr (r_wa),
    .i_ra1      (chk_ra1_i),
    .i_ra2      (chk_ra2_i),
    .o_hazard   (hazard_o)
  );

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed vector bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       issue_i = 1'b0;
  logic [4:0] issue_rd_i = '0;
  logic [4:0] chk_ra1_i = '0;
  logic [4:0] chk_ra2_i = '0;
  logic       hazard_o;

  int total = 0;
  int bad   = 0;

  rf_wb_arbiter_if #(.XLEN(32), .AW(5)) bus ();

  rf_wb_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .issue_i    (issue_i),
    .issue_rd_i (issue_rd_i),
    .chk_ra1_i  (chk_ra1_i),
    .chk_ra2_i  (chk_ra2_i),
    .hazard_o   (hazard_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  awa;
    logic [31:0] awd;
    logic        lv;
    logic [4:0]  lwa;
    logic [31:0] lwd;
    logic        iss;
    logic [4:0]  ird;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic        ar;
    logic        lr;
    logic        hz;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic av, input logic [4:0] awa, input logic [31:0] awd,
                     input logic lv, input logic [4:0] lwa, input logic [31:0] lwd,
                     input logic iss, input logic [4:0] ird,
                     input logic [4:0] ra1, input logic [4:0] ra2,
                     input logic ar, input logic lr, input logic hz,
                     input logic we, input logic [4:0] wa, input logic [31:0] wd);
    vec_t v;
    v.av = av; v.awa = awa; v.awd = awd;
    v.lv = lv; v.lwa = lwa; v.lwd = lwd;
    v.iss = iss; v.ird = ird; v.ra1 = ra1; v.ra2 = ra2;
    v.ar = ar; v.lr = lr; v.hz = hz; v.we = we; v.wa = wa; v.wd = wd;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] awa, input logic [31:0] awd,
                       input logic lv, input logic [4:0] lwa, input logic [31:0] lwd,
                       input logic iss, input logic [4:0] ird,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    bus.alu_valid_i = av; bus.alu_wa_i = awa; bus.alu_wd_i = awd;
    bus.lsu_valid_i = lv; bus.lsu_wa_i = lwa; bus.lsu_wd_i = lwd;
    issue_i = iss; issue_rd_i = ird; chk_ra1_i = ra1; chk_ra2_i = ra2;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    //   av awa awd       lv lwa lwd       iss ird ra1 ra2  ar lr hz we wa wd
    // starvation: LSU x4, ALU forced, LSU
    add(1, 20, 32'hA0,   1, 10, 32'h100, 0, 0, 0, 0,  0, 1, 0, 0, 0,  0);
    add(1, 20, 32'hA0,   1, 11, 32'h101, 0, 0, 0, 0,  0, 1, 0, 1, 10, 32'h100);
    add(1, 20, 32'hA0,   1, 12, 32'h102, 0, 0, 0, 0,  0, 1, 0, 1, 11, 32'h101);
    add(1, 20, 32'hA0,   1, 13, 32'h103, 0, 0, 0, 0,  0, 1, 0, 1, 12, 32'h102);
    add(1, 20, 32'hA0,   1, 14, 32'h104, 0, 0, 0, 0,  1, 0, 0, 1, 13, 32'h103);
    add(1, 20, 32'hA0,   1, 15, 32'h105, 0, 0, 0, 0,  0, 1, 0, 1, 20, 32'hA0);
    add(0, 0,  0,        0, 0,  0,       0, 0, 0, 0,  1, 1, 0, 1, 15, 32'h105);
    add(0, 0,  0,        0, 0,  0,       0, 0, 0, 0,  1, 1, 0, 0, 0,  0);
    // back-to-back ALU writes
    add(1, 1,  32'h1001, 0, 0,  0,       0, 0, 0, 0,  1, 1, 0, 0, 0,  0);
    add(1, 2,  32'h1002, 0, 0,  0,       0, 0, 0, 0,  1, 1, 0, 1, 1,  32'h1001);
    add(1, 3,  32'h1003, 0, 0,  0,       0, 0, 0, 0,  1, 1, 0, 1, 2,  32'h1002);
    add(1, 4,  32'h1004, 0, 0,  0,       0, 0, 0, 0,  1, 1, 0, 1, 3,  32'h1003);
    add(0, 0,  0,        0, 0,  0,       0, 0, 0, 0,  1, 1, 0, 1, 4,  32'h1004);
    add(0, 0,  0,        0, 0,  0,       0, 0, 0, 0,  1, 1, 0, 0, 0,  0);
    // x0 write is accepted but dropped
    add(1, 0,  32'h1234, 0, 0,  0,       0, 0, 0, 0,  1, 1, 0, 0, 0,  0);
    add(0, 0,  0,        0, 0,  0,       0, 0, 0, 0,  1, 1, 0, 0, 0,  0);
    // scoreboard lifecycle on r5
    add(0, 0,  0,        0, 0,  0,       1, 5, 5, 0,  1, 1, 0, 0, 0,  0);
    add(0, 0,  0,        0, 0,  0,       0, 0, 5, 0,  1, 1, 1, 0, 0,  0);
    add(1, 5,  32'h55,   0, 0,  0,       0, 0, 5, 0,  1, 1, 1, 0, 0,  0);
    add(0, 0,  0,        0, 0,  0,       0, 0, 5, 0,  1, 1, 1, 1, 5,  32'h55);
    add(0, 0,  0,        0, 0,  0,       0, 0, 5, 0,  1, 1, 0, 0, 0,  0);
    // set/clear collision on r7
    add(0, 0,  0,        0, 0,  0,       1, 7, 0, 7,  1, 1, 0, 0, 0,  0);
    add(1, 7,  32'h77,   0, 0,  0,       0, 0, 0, 7,  1, 1, 1, 0, 0,  0);
    add(0, 0,  0,        0, 0,  0,       1, 7, 0, 7,  1, 1, 1, 1, 7,  32'h77);
    add(0, 0,  0,        0, 0,  0,       0, 0, 0, 7,  1, 1, 1, 0, 0,  0);
    add(1, 7,  32'h78,   0, 0,  0,       0, 0, 0, 7,  1, 1, 1, 0, 0,  0);
    add(0, 0,  0,        0, 0,  0,       0, 0, 0, 7,  1, 1, 1, 1, 7,  32'h78);
    add(0, 0,  0,        0, 0,  0,       0, 0, 0, 7,  1, 1, 0, 0, 0,  0);
    // LSU x0 write and issue to x0; ALU ready independent of its own valid
    add(0, 0,  0,        1, 0,  32'hBAD, 1, 0, 0, 0,  0, 1, 0, 0, 0,  0);
    add(0, 0,  0,        0, 0,  0,       0, 0, 0, 0,  1, 1, 0, 0, 0,  0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset.we", 32'(bus.rf_we_o), 32'd0);
    chk("reset.wa", 32'(bus.rf_wa_o), 32'd0);
    chk("reset.wd", bus.rf_wd_o, 32'd0);

    for (int i = 0; i < vq.size(); i++) begin
      vec_t v;
      v = vq[i];
      @(negedge clk);
      drive(v.av, v.awa, v.awd, v.lv, v.lwa, v.lwd, v.iss, v.ird, v.ra1, v.ra2);
      #1;
      chk($sformatf("v%0d.alu_ready", i), 32'(bus.alu_ready_o), 32'(v.ar));
      chk($sformatf("v%0d.lsu_ready", i), 32'(bus.lsu_ready_o), 32'(v.lr));
      chk($sformatf("v%0d.hazard", i), 32'(hazard_o), 32'(v.hz));
      chk($sformatf("v%0d.we", i), 32'(bus.rf_we_o), 32'(v.we));
      if (v.we) begin
        chk($sformatf("v%0d.wa", i), 32'(bus.rf_wa_o), 32'(v.wa));
        chk($sformatf("v%0d.wd", i), bus.rf_wd_o, v.wd);
      end
    end

    // reset with an LSU write sitting in the output register
    @(negedge clk);
    drive(0, 0, 0, 1, 3, 32'hDEAD_BEEF, 1, 9, 0, 0);
    #1;
    chk("rmw.lsu_ready", 32'(bus.lsu_ready_o), 32'd1);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 9, 3);
    rst = 1'b1;
    #1;
    chk("rmw.we_before", 32'(bus.rf_we_o), 32'd1);
    chk("rmw.wa_before", 32'(bus.rf_wa_o), 32'd3);
    chk("rmw.wd_before", bus.rf_wd_o, 32'hDEAD_BEEF);
    chk("rmw.hz_before", 32'(hazard_o), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rmw.we_after", 32'(bus.rf_we_o), 32'd0);
    chk("rmw.wa_after", 32'(bus.rf_wa_o), 32'd0);
    chk("rmw.wd_after", bus.rf_wd_o, 32'd0);
    for (int r = 0; r < 32; r++) begin
      @(negedge clk);
      chk_ra1_i = 5'(r);
      chk_ra2_i = 5'(31 - r);
      #1;
      chk($sformatf("rmw.busy%0d", r), 32'(hazard_o), 32'd0);
    end

    // starve counter is cleared by reset
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1, 21, 32'hC0, 1, 22, 32'hD0, 0, 0, 0, 0);
      #1;
      chk($sformatf("sr.pre%0d.lsu_ready", c), 32'(bus.lsu_ready_o), 32'd1);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("sr.inreset.lsu_ready", 32'(bus.lsu_ready_o), 32'd1);
    chk("sr.inreset.alu_ready", 32'(bus.alu_ready_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk($sformatf("sr.post%0d.alu_ready", c), 32'(bus.alu_ready_o), (c == 4) ? 32'd1 : 32'd0);
      chk($sformatf("sr.post%0d.lsu_ready", c), 32'(bus.lsu_ready_o), (c == 4) ? 32'd0 : 32'd1);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
